imem_loader: RTL and testbench

- Instruction-memory front end for the single-cycle sorting core (dpath).
- Accepts a program as a stream of 32-bit words over a valid/ready handshake, stores it in an internal word array, and holds the core in reset while loading.
- Once loading completes, it releases the core and serves combinational instruction fetch (pc in, ins out) in the same cycle, as a single-cycle core requires.

---
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory front end: streams a program into a word array while the
// core is held in reset, then serves combinational fetch to the running core.
module imem_loader #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       ins,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   prog_len,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [ADDR_W:0] r_prog_len;
  logic [31:0]     r_checksum;
  logic [31:0]     r_mem [DEPTH];

  logic w_xfer;
  logic w_clear;
  logic w_at_last_slot;
  logic w_in_prog;
  logic w_unused;

  assign w_xfer         = (r_state == S_LOAD) && in_valid;
  assign w_clear        = start && (r_state != S_LOAD);
  assign w_at_last_slot = (r_prog_len == (ADDR_W+1)'(DEPTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_xfer) begin
          if (in_last)             w_next_state = S_RUN;
          else if (w_at_last_slot) w_next_state = S_ERR;
        end
      end
      S_RUN:  if (start) w_next_state = S_LOAD;
      S_ERR:  if (start) w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prog_len <= '0;
      r_checksum <= '0;
    end else if (w_clear) begin
      r_prog_len <= '0;
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_prog_len <= r_prog_len + 1'b1;
      r_checksum <= r_checksum + in_data;
    end
  end

  // NOTE: the array has no reset; stale words are unreachable because fetch
  // is gated by prog_len, which does reset.
  always_ff @(posedge clk) begin
    if (w_xfer) r_mem[r_prog_len[ADDR_W-1:0]] <= in_data;
  end

  // Word index compared at full width so any pc beyond the array reads NOP.
  assign w_in_prog = ({2'b00, pc[31:2]} < 32'(r_prog_len));
  assign w_unused  = &{1'b0, pc[1:0]};

  always_comb begin
    ins = NOP_WORD;
    if (r_state == S_RUN && w_in_prog) ins = r_mem[pc[ADDR_W+1:2]];
  end

  assign in_ready = (r_state == S_LOAD);
  assign core_rst = (r_state != S_RUN);
  assign done     = (r_state == S_RUN);
  assign error    = (r_state == S_ERR);
  assign prog_len = r_prog_len;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance for load/fetch/reload
// and a DEPTH=4 instance for the overflow and last-slot boundaries.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start, in_valid, in_last, in_ready, core_rst, done, error;
  logic [31:0] in_data, pc, ins, checksum;
  logic [8:0]  prog_len;

  logic        b_start, b_in_valid, b_in_last, b_in_ready, b_core_rst, b_done, b_error;
  logic [31:0] b_in_data, b_pc, b_ins, b_checksum;
  logic [2:0]  b_prog_len;

  imem_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .pc(pc), .ins(ins), .core_rst(core_rst),
    .done(done), .error(error), .prog_len(prog_len), .checksum(checksum)
  );

  imem_loader #(.DEPTH(4), .ADDR_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_last(b_in_last), .in_ready(b_in_ready), .pc(b_pc), .ins(b_ins),
    .core_rst(b_core_rst), .done(b_done), .error(b_error), .prog_len(b_prog_len),
    .checksum(b_checksum)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, ins, exp);
  endtask

  task automatic b_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    b_pc = addr;
    #1;
    check(tag, b_ins, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] d, input logic last);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
    tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 0; in_valid = 0; in_data = 0; in_last = 0; pc = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    fetch("rst_ins_pc0", 32'd0, NOP);

    // Normal load; in_valid already high alongside start must not transfer
    start = 1'b1; in_valid = 1'b1; in_data = 32'h00500293;
    tick();
    start = 1'b0;
    check("load_prog_len0", 32'(prog_len), 32'd0);
    check("load_in_ready",  32'(in_ready), 32'd1);
    check("load_ins_nop",   ins, NOP);
    push(32'h00500293, 1'b0);
    push(32'h00600313, 1'b0);
    check("load_core_rst_mid", 32'(core_rst), 32'd1);
    push(32'h0000006F, 1'b1);
    check("load_prog_len", 32'(prog_len), 32'd3);
    check("load_checksum", checksum, 32'h00500293 + 32'h00600313 + 32'h0000006F);
    check("load_done",     32'(done),     32'd1);
    check("load_core_rst", 32'(core_rst), 32'd0);
    check("load_in_ready_run", 32'(in_ready), 32'd0);
    fetch("fetch_pc0",   32'd0,  32'h00500293);
    fetch("fetch_pc2",   32'd2,  32'h00500293);
    fetch("fetch_pc8",   32'd8,  32'h0000006F);
    fetch("fetch_pc12",  32'd12, NOP);
    fetch("fetch_pc1024", 32'd1024, NOP);
    fetch("fetch_pc_hi", 32'h80000000, NOP);

    // Reload from RUN, then a gapped stream with a stray start in LOAD
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_core_rst", 32'(core_rst), 32'd1);
    check("reload_prog_len", 32'(prog_len), 32'd0);
    check("reload_checksum", checksum, 32'd0);
    check("reload_done",     32'(done), 32'd0);
    push(32'hAAAA0001, 1'b0);
    in_data = 32'hBBBB0002; start = 1'b1;
    tick();
    start = 1'b0; in_data = 32'hCCCC0003;
    tick();
    check("gap_prog_len_mid", 32'(prog_len), 32'd1);
    check("gap_in_ready_mid", 32'(in_ready), 32'd1);
    push(32'hDDDD0004, 1'b1);
    check("gap_prog_len",  32'(prog_len), 32'd2);
    check("gap_checksum",  checksum, 32'hAAAA0001 + 32'hDDDD0004);
    check("gap_done",      32'(done), 32'd1);
    fetch("gap_pc0", 32'd0, 32'hAAAA0001);
    fetch("gap_pc4", 32'd4, 32'hDDDD0004);
    fetch("gap_pc8", 32'd8, NOP);

    // Single-word program
    start = 1'b1;
    tick();
    start = 1'b0;
    push(32'h00000013, 1'b1);
    check("one_prog_len", 32'(prog_len), 32'd1);
    check("one_done",     32'(done), 32'd1);
    fetch("one_pc4", 32'd4, NOP);

    // Async reset mid-load, no clock edge in between
    start = 1'b1;
    tick();
    start = 1'b0;
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    check("arst_pre_len", 32'(prog_len), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_prog_len", 32'(prog_len), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_core_rst", 32'(core_rst), 32'd1);
    tick();
    rst = 1'b0;

    // Overflow on DEPTH=4 instance
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_push(32'h00000001, 1'b0);
    b_push(32'h00000002, 1'b0);
    b_push(32'h00000003, 1'b0);
    check("ovf_ready_slot3", 32'(b_in_ready), 32'd1);
    b_push(32'hFFFFFFFF, 1'b0);
    check("ovf_error",    32'(b_error),    32'd1);
    check("ovf_in_ready", 32'(b_in_ready), 32'd0);
    check("ovf_core_rst", 32'(b_core_rst), 32'd1);
    check("ovf_prog_len", 32'(b_prog_len), 32'd4);
    check("ovf_checksum", b_checksum, 32'd5);
    b_fetch("ovf_ins_nop", 32'd0, NOP);
    b_push(32'h12345678, 1'b0);
    check("ovf_hold_len", 32'(b_prog_len), 32'd4);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("ovf_clr_error", 32'(b_error),    32'd0);
    check("ovf_clr_ready", 32'(b_in_ready), 32'd1);
    check("ovf_clr_len",   32'(b_prog_len), 32'd0);
    check("ovf_clr_sum",   b_checksum, 32'd0);

    // Last slot with in_last is a legal full program
    b_push(32'h0A0A0A0A, 1'b0);
    b_push(32'h0B0B0B0B, 1'b0);
    b_push(32'h0C0C0C0C, 1'b0);
    b_push(32'h0D0D0D0D, 1'b1);
    check("full_done",     32'(b_done),     32'd1);
    check("full_error",    32'(b_error),    32'd0);
    check("full_prog_len", 32'(b_prog_len), 32'd4);
    b_fetch("full_pc12", 32'd12, 32'h0D0D0D0D);
    b_fetch("full_pc16", 32'd16, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
